// File: rtl/char_fifo_pkg.sv
// Shared constants for the character FIFO between the character generator
// and the UART transmitter.
package char_fifo_pkg;

    localparam int CHAR_WIDTH    = 8;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_AFULL = 12;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/char_fifo_if.sv
// Handshake bundle between the character generator / UART side (master) and
// the FIFO (slave).
interface char_fifo_if
    import char_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CHAR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
);
    localparam int CNT_W = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] char_fifo_din;
    logic                  char_fifo_wr_en;
    logic                  char_fifo_full;
    logic                  char_fifo_afull;
    logic                  char_fifo_rd_en;
    logic [DATA_WIDTH-1:0] char_fifo_dout;
    logic                  char_fifo_empty;
    logic [CNT_W-1:0]      char_fifo_count;
    logic                  char_fifo_ovf;
    logic                  ovf_clr;

    modport master (
        output char_fifo_din, char_fifo_wr_en, char_fifo_rd_en, ovf_clr,
        input  char_fifo_full, char_fifo_afull, char_fifo_dout,
               char_fifo_empty, char_fifo_count, char_fifo_ovf
    );

    modport slave (
        input  char_fifo_din, char_fifo_wr_en, char_fifo_rd_en, ovf_clr,
        output char_fifo_full, char_fifo_afull, char_fifo_dout,
               char_fifo_empty, char_fifo_count, char_fifo_ovf
    );

endinterface

// File: rtl/char_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset,
// written so that synthesis maps it onto block or distributed RAM.
module char_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_tx,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_p1
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read-before-write on an address collision; the caller bypasses that case.
    always_ff @(posedge clk_tx) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_p1 <= mem[rd_addr];
    end

endmodule

// File: rtl/char_fifo_fwft.sv
// First-word-fall-through character FIFO: pointers, occupancy, flags and the
// head-word output stage around a registered-read RAM.
module char_fifo_fwft
    import char_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = CHAR_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int AFULL_THRESH = DEFAULT_AFULL
) (
    input  logic        clk_tx,
    input  logic        rst_clk_tx_n,
    char_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, afull_q, empty_q, ovf_q;
    logic                  push, pop, ovf_evt;
    logic                  byp_sel_p1;
    logic [DATA_WIDTH-1:0] byp_data_p1;
    logic [DATA_WIDTH-1:0] ram_rd_p1;

    // A pop frees the slot the coincident push needs, so a full FIFO still
    // accepts a push in the same cycle it is read.
    assign pop     = bus.char_fifo_rd_en && !empty_q;
    assign push    = bus.char_fifo_wr_en && (!full_q || pop);
    assign ovf_evt = bus.char_fifo_wr_en && full_q && !pop;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            byp_sel_p1 <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CW'(DEPTH));
            afull_q <= (count_nxt >= CW'(AFULL_THRESH));
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
            // The word being written becomes the new head: RAM would return stale data.
            byp_sel_p1 <= push && (wr_ptr == rd_ptr_nxt);
        end
    end

    // ---- stage p1: head word capture (data path, not reset) ----
    always_ff @(posedge clk_tx) begin
        byp_data_p1 <= bus.char_fifo_din;
    end

    char_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk_tx     (clk_tx),
        .wr_en      (push),
        .wr_addr    (wr_ptr),
        .wr_data    (bus.char_fifo_din),
        .rd_addr    (rd_ptr_nxt),
        .rd_data_p1 (ram_rd_p1)
    );

    assign bus.char_fifo_dout  = empty_q ? '0 : (byp_sel_p1 ? byp_data_p1 : ram_rd_p1);
    assign bus.char_fifo_empty = empty_q;
    assign bus.char_fifo_full  = full_q;
    assign bus.char_fifo_afull = afull_q;
    assign bus.char_fifo_count = count_q;
    assign bus.char_fifo_ovf   = ovf_q;

endmodule

// File: tb/tb_char_fifo_fwft.sv
// Randomised and directed stimulus for char_fifo_fwft, checked against a
// queue-based model of the FIFO's externally visible behaviour.
module tb_char_fifo_fwft;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clk_tx;
    logic rst_n;

    char_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    char_fifo_fwft #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_n),
        .bus          (bus)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic          model_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = model_q.size();
        check({tag, "_count"}, 32'(bus.char_fifo_count), 32'(n));
        check({tag, "_empty"}, 32'(bus.char_fifo_empty), 32'(n == 0));
        check({tag, "_full"},  32'(bus.char_fifo_full),  32'(n == DEPTH));
        check({tag, "_afull"}, 32'(bus.char_fifo_afull), 32'(n >= AFULL));
        check({tag, "_ovf"},   32'(bus.char_fifo_ovf),   32'(model_ovf));
        if (n != 0) begin
            check({tag, "_dout"}, 32'(bus.char_fifo_dout), 32'(model_q[0]));
        end
    endtask

    // Called at a falling edge: drive, let one rising edge happen, update the
    // model from what that edge sampled, then compare at the next falling edge.
    task automatic cycle(input string tag, input logic wr, input logic [DW-1:0] d,
                         input logic rd, input logic clr);
        bit was_full, was_empty, do_pop, do_push;
        bus.char_fifo_wr_en = wr;
        bus.char_fifo_din   = d;
        bus.char_fifo_rd_en = rd;
        bus.ovf_clr         = clr;
        @(posedge clk_tx);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        do_pop    = rd && !was_empty;
        do_push   = wr && (!was_full || do_pop);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        if (wr && was_full && !do_pop) model_ovf = 1'b1;
        else if (clr)                  model_ovf = 1'b0;
        @(negedge clk_tx);
        bus.char_fifo_wr_en = 1'b0;
        bus.char_fifo_rd_en = 1'b0;
        bus.ovf_clr         = 1'b0;
        check_outputs(tag);
    endtask

    task automatic fill_to(input string tag, input int n);
        while (model_q.size() < n) cycle(tag, 1'b1, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.char_fifo_din   = '0;
        bus.char_fifo_wr_en = 1'b0;
        bus.char_fifo_rd_en = 1'b0;
        bus.ovf_clr         = 1'b0;
        repeat (2) @(posedge clk_tx);
        @(negedge clk_tx);
        check_outputs("reset");
        check("reset_dout", 32'(bus.char_fifo_dout), 32'h0);
        rst_n = 1'b1;

        // Single push into empty, then pop back to empty
        cycle("push41", 1'b1, 8'h41, 1'b0, 1'b0);
        cycle("pop41",  1'b0, 8'h00, 1'b1, 1'b0);

        // Fill 0x00..0x0F, overflow with 0xAA, drain in order
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        cycle("ovf_push", 1'b1, 8'hAA, 1'b0, 1'b0);
        drain("drain");
        cycle("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Push+pop at count 1
        cycle("one", 1'b1, 8'h10, 1'b0, 1'b0);
        cycle("pp_one", 1'b1, 8'h55, 1'b1, 1'b0);

        // Push+pop at full, 0x77 must come out last
        fill_to("fill2", DEPTH);
        cycle("pp_full", 1'b1, 8'h77, 1'b1, 1'b0);
        drain("drain2");

        // Streaming around count 8 across pointer wrap
        fill_to("fill8", 8);
        for (int i = 0; i < 40; i++)
            cycle("stream", 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);

        // Write-biased then read-biased random phases reach full, overflow, empty
        for (int i = 0; i < 150; i++)
            cycle("rand_w", ($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0,
                  ($urandom % 8) == 0);
        for (int i = 0; i < 150; i++)
            cycle("rand_r", ($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0,
                  ($urandom % 8) == 0);

        // ovf_clr coincident with an overflow: set wins
        fill_to("fill3", DEPTH);
        cycle("clr_vs_set", 1'b1, 8'hEE, 1'b0, 1'b1);

        // Asynchronous reset with count 5 in the middle of a pop
        drain("drain3");
        fill_to("fill5", 5);
        cycle("ovf_mk", 1'b0, 8'h00, 1'b0, 1'b0);
        bus.char_fifo_rd_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_outputs("arst");
        check("arst_dout", 32'(bus.char_fifo_dout), 32'h0);
        bus.char_fifo_rd_en = 1'b0;
        @(posedge clk_tx);
        @(negedge clk_tx);
        check_outputs("arst_hold");
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 8'h3C, 1'b0, 1'b0);
        cycle("post_rst2", 1'b1, 8'hC3, 1'b1, 1'b0);
        drain("drain4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_fifo_fwft.md
CHAR_FIFO_FWFT -- requirements
Module: char_fifo_fwft

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning character width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning total word capacity; power of 2, 4..1024.
REQ-003 SHALL have parameter AFULL_THRESH, default 12, meaning count at or above which char_fifo_afull asserts; range 1..DEPTH.
REQ-004 SHALL have port clk_tx, input, 1 bit: the single clock for the whole block.
REQ-005 SHALL have port rst_clk_tx_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port char_fifo_din, input, DATA_WIDTH bits: write data from the character generator.
REQ-007 SHALL have port char_fifo_wr_en, input, 1 bit: push request.
REQ-008 SHALL have port char_fifo_full, output, 1 bit: no space for a push.
REQ-009 SHALL have port char_fifo_afull, output, 1 bit: count >= AFULL_THRESH.
REQ-010 SHALL have port char_fifo_rd_en, input, 1 bit: pop from the UART transmitter.
REQ-011 SHALL have port char_fifo_dout, output, DATA_WIDTH bits: head word, valid whenever char_fifo_empty=0.
REQ-012 SHALL have port char_fifo_empty, output, 1 bit: no valid head word.
REQ-013 SHALL have port char_fifo_count, output, log2(DEPTH)+1 bits: words held, including the head word.
REQ-014 SHALL have port char_fifo_ovf, output, 1 bit: sticky overflow flag.
REQ-015 SHALL have port ovf_clr, input, 1 bit: synchronous clear of char_fifo_ovf.

Function
REQ-016 SHALL operate as first-word-fall-through: the head word is presented on char_fifo_dout without a read request.
REQ-017 SHALL register all outputs; there SHALL be no combinational path from any input to any output.
REQ-018 SHALL accept a push when char_fifo_wr_en=1 and char_fifo_full=0.
REQ-019 SHALL drop the data of a push made while full, leave all state unchanged, and set char_fifo_ovf=1 on the next edge.
REQ-020 SHALL perform a pop when char_fifo_rd_en=1 and char_fifo_empty=0; rd_en while empty SHALL be ignored with no state change and no flag.
REQ-021 Push into an empty FIFO at edge N SHALL give char_fifo_empty=0 and dout=pushed word after edge N+1 (1-cycle latency).
REQ-022 Pop at edge N SHALL present the next word after edge N+1, or char_fifo_empty=1 if count was 1.
REQ-023 A simultaneous accepted push and pop SHALL leave count unchanged; with count=1, empty SHALL stay 0 and dout SHALL become the pushed word.
REQ-024 A pop while full with a simultaneous push SHALL accept the push (full recomputed from the post-pop count), with count remaining DEPTH.
REQ-025 char_fifo_full SHALL equal (count==DEPTH) and char_fifo_afull SHALL equal (count>=AFULL_THRESH), both updated on the same edge as count.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-027 Word order SHALL be strictly preserved across pointer wrap-around.
REQ-028 ovf_clr=1 SHALL clear char_fifo_ovf; if an overflow occurs in the same cycle, set SHALL win.

Reset
REQ-029 Assertion of rst_clk_tx_n=0 SHALL immediately force count=0, pointers=0, char_fifo_empty=1, char_fifo_full=0, char_fifo_afull=0, char_fifo_ovf=0 and char_fifo_dout=0.
REQ-030 Reset mid-operation SHALL discard all stored words; the storage array itself SHALL not be reset.
REQ-031 Deassertion of rst_clk_tx_n SHALL be synchronised to clk_tx outside this block; the first push is accepted on the first edge after deassertion.

Structure
REQ-032 Package char_fifo_pkg SHALL hold CHAR_WIDTH=8, the default DEPTH, and the count-width constant/function.
REQ-033 Storage SHALL be a sub-module char_fifo_ram: simple dual-port, 1 write port and 1 registered read port, no reset, RAM-inferable.
REQ-034 Control (pointers, count, flags, output stage) SHALL reside in char_fifo_fwft.

Verification
REQ-035 Push 0x41 into empty FIFO -> empty falls one cycle later, dout=0x41, count=1.
REQ-036 Push 16 words 0x00..0x0F, then push 0xAA -> full=1 after the 16th push, afull=1 from count 12, 0xAA dropped, ovf=1; pop all -> 0x00..0x0F in order, empty=1.
REQ-037 At count=1, simultaneous push 0x55 and pop -> dout=0x55 next cycle, empty stays 0, count=1.
REQ-038 At full, simultaneous push 0x77 and pop -> count stays 16, 0x77 read out last.
REQ-039 40 push/pop cycles at count ~8 crossing pointer wrap -> output sequence equals input sequence; rd_en while empty -> no change.
REQ-040 Reset asserted with count=5 mid-pop -> empty=1, count=0, ovf=0 immediately; ovf_clr with coincident overflow -> ovf stays 1.
